v_cnt_btn: RTL and testbench

Debounced push-button production counter for the factory-floor calculator board. It takes the three raw board buttons (increment, decrement, clear) and maintains a saturating decimal-range count from 0 to 9999. The 14-bit binary count drives the 14-bit value input of the four-digit seven-segment display multiplexer directly downstream. All state is synchronous to the single board clock.

---
 rtl/v_cnt_btn.sv | 81 ++++++++
 tb/tb_v_cnt_btn.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/v_cnt_btn.sv
// Push-button production counter: three raw buttons are synchronized, debounced
// and edge-detected, then step a count saturating in 0..MAX.
module v_cnt_btn #(
    parameter int unsigned DEBOUNCE = 1000000,
    parameter int unsigned MAX      = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_clr,
    output logic [13:0] count,
    output logic        at_max,
    output logic        at_zero
);

    localparam int unsigned   NB    = 3;
    localparam int unsigned   DW    = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);
    localparam logic [13:0]   CMAX  = 14'(MAX);

    // Bit order across all per-button vectors: [0]=inc, [1]=dec, [2]=clr.
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] stable;
    logic [NB-1:0] stable_q;
    logic [NB-1:0] press;
    logic [DW-1:0] dcnt [NB];

    assign raw = {btn_clr, btn_dec, btn_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DLAST) begin
                    stable[i] <= sync2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    // One-cycle pulse per accepted press; releases produce nothing.
    assign press = stable & ~stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (press[2]) begin
            count <= '0;
        end else if (press[0] && !press[1]) begin
            if (count < CMAX) begin
                count <= count + 14'd1;
            end
        end else if (press[1] && !press[0]) begin
            if (count != '0) begin
                count <= count - 14'd1;
            end
        end
    end

    assign at_max  = (count == CMAX);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_v_cnt_btn.sv
// Bench for v_cnt_btn: a sliding-window debounce/count model checked every cycle
// on two instances (full range and a small ceiling), plus literal directed checks.
module tb_v_cnt_btn;

    localparam int unsigned DEB  = 4;
    localparam int unsigned MAXA = 9999;
    localparam int unsigned MAXB = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_inc, btn_dec, btn_clr;
    logic [13:0] count_a, count_b;
    logic        at_max_a, at_zero_a, at_max_b, at_zero_b;

    int tests = 0;
    int fails = 0;
    bit running = 1'b0;

    always #5 clk = ~clk;

    v_cnt_btn #(.DEBOUNCE(DEB), .MAX(MAXA)) dut_a (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .count(count_a), .at_max(at_max_a), .at_zero(at_zero_a)
    );

    v_cnt_btn #(.DEBOUNCE(DEB), .MAX(MAXB)) dut_b (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .count(count_b), .at_max(at_max_b), .at_zero(at_zero_b)
    );

    // ---------------- reference model ----------------
    int unsigned mmax [2] = '{MAXA, MAXB};
    int          m_count [2];
    logic [2:0]  m_s1, m_s2, m_stable, m_stable_q;
    logic [2:0]  m_hist [$];   // last DEB synchronized samples since reset

    function automatic int apply(input int c, input logic [2:0] p, input int unsigned mx);
        if (p[2])         return 0;
        if (p[0] && p[1]) return c;
        if (p[0])         return (c < int'(mx)) ? c + 1 : c;
        if (p[1])         return (c > 0) ? c - 1 : c;
        return c;
    endfunction

    always @(posedge clk) begin
        logic [2:0] pend;
        logic [2:0] newst;
        bit         all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_q = '0;
            m_hist = {};
            m_count[0] = 0; m_count[1] = 0;
        end else begin
            pend = m_stable & ~m_stable_q;
            for (int unsigned u = 0; u < 2; u++) m_count[u] = apply(m_count[u], pend, mmax[u]);
            m_hist.push_back(m_s2);
            if (m_hist.size() > int'(DEB)) void'(m_hist.pop_front());
            // A level is accepted once the last DEB synchronized samples all disagree with it.
            newst = m_stable;
            for (int unsigned b = 0; b < 3; b++) begin
                all_diff = (m_hist.size() == int'(DEB));
                foreach (m_hist[j]) if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) newst[b] = ~m_stable[b];
            end
            m_stable_q = m_stable;
            m_stable   = newst;
            m_s2 = m_s1;
            m_s1 = {btn_clr, btn_dec, btn_inc};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check("cmp_count_a",   32'(count_a),   32'(m_count[0]));
            check("cmp_atmax_a",   32'(at_max_a),  32'(m_count[0] == int'(MAXA)));
            check("cmp_atzero_a",  32'(at_zero_a), 32'(m_count[0] == 0));
            check("cmp_count_b",   32'(count_b),   32'(m_count[1]));
            check("cmp_atmax_b",   32'(at_max_b),  32'(m_count[1] == int'(MAXB)));
            check("cmp_atzero_b",  32'(at_zero_b), 32'(m_count[1] == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] m);
        {btn_clr, btn_dec, btn_inc} = m;
    endtask

    task automatic press(input logic [2:0] m);
        set_btn(m);
        repeat (7) step();
        set_btn(3'b000);
        repeat (6) step();
    endtask

    initial begin
        rst = 1'b1;
        set_btn(3'b000);
        repeat (2) step();
        running = 1'b1;
        check("reset_count",  32'(count_a),   32'd0);
        check("reset_atzero", 32'(at_zero_a), 32'd1);
        check("reset_atmax",  32'(at_max_a),  32'd0);
        check("reset_model",  32'(m_count[0]), 32'd0);
        rst = 1'b0;
        step();

        // Held increment: count changes exactly after edge 6.
        btn_inc = 1'b1;
        for (int unsigned e = 0; e < 6; e++) begin
            step();
            check("hold_pre_edge6", 32'(count_a), 32'd0);
        end
        step();
        check("hold_edge6",       32'(count_a),    32'd1);
        check("hold_edge6_zero",  32'(at_zero_a),  32'd0);
        check("hold_edge6_model", 32'(m_count[0]), 32'd1);
        repeat (10) step();
        check("hold_no_repeat", 32'(count_a), 32'd1);
        btn_inc = 1'b0;
        repeat (8) step();

        // Bounce (3 high / 2 low) is rejected, steady high accepted 6 edges later.
        repeat (4) begin
            btn_inc = 1'b1; repeat (3) step();
            btn_inc = 1'b0; repeat (2) step();
        end
        check("bounce_ignored", 32'(count_a), 32'd1);
        btn_inc = 1'b1;
        for (int unsigned e = 0; e < 6; e++) begin
            step();
            check("bounce_pre_edge6", 32'(count_a), 32'd1);
        end
        step();
        check("bounce_edge6", 32'(count_a), 32'd2);
        btn_inc = 1'b0;
        repeat (8) step();

        repeat (5) press(3'b001);
        check("count_7", 32'(count_a), 32'd7);

        // Reset mid-debounce of a held decrement, then floor at 0.
        btn_dec = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rst_mid_count", 32'(count_a), 32'd0);
        rst = 1'b0;
        repeat (12) step();
        check("rst_floor",       32'(count_a),    32'd0);
        check("rst_floor_zero",  32'(at_zero_a),  32'd1);
        check("rst_floor_model", 32'(m_count[0]), 32'd0);
        btn_dec = 1'b0;
        repeat (8) step();

        // Saturation on the small-ceiling instance.
        repeat (19) press(3'b001);
        check("sat_19", 32'(count_b), 32'd19);
        press(3'b001);
        check("sat_20",       32'(count_b),  32'd20);
        check("sat_20_atmax", 32'(at_max_b), 32'd1);
        press(3'b001);
        check("sat_hold",       32'(count_b),    32'd20);
        check("sat_hold_atmax", 32'(at_max_b),   32'd1);
        check("sat_hold_model", 32'(m_count[1]), 32'd20);
        check("sat_a_21",       32'(count_a),    32'd21);

        press(3'b100);
        check("clr_a", 32'(count_a), 32'd0);
        check("clr_b", 32'(count_b), 32'd0);
        press(3'b010);
        check("dec_floor",      32'(count_a),   32'd0);
        check("dec_floor_zero", 32'(at_zero_a), 32'd1);

        repeat (50) press(3'b001);
        check("count_50", 32'(count_a), 32'd50);
        press(3'b011);
        check("inc_dec_same", 32'(count_a), 32'd50);
        press(3'b101);
        check("clr_inc_same", 32'(count_a), 32'd0);
        check("clr_inc_model", 32'(m_count[0]), 32'd0);

        // Random press/release segments, each held at least 10 cycles.
        for (int unsigned s = 0; s < 300; s++) begin
            logic [2:0] m;
            m[0] = ($urandom_range(0, 99) < 55);
            m[1] = ($urandom_range(0, 99) < 35);
            m[2] = ($urandom_range(0, 99) < 4);
            set_btn(m);
            repeat ($urandom_range(10, 16)) step();
        end

        set_btn(3'b000);
        repeat (10) step();
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
